// File: rtl/doodler_ctrl.sv
// doodler_ctrl: doodler control FSM, advanced once per video frame.
//
// Decodes up to NUM_KEYS simultaneous USB keycodes into a facing direction, a
// latched shot direction and a one-frame fire strobe. A shot runs SHOOT_FRAMES
// frames, then COOLDOWN_FRAMES frames (skipped when 0), then returns to the
// RIGHT/LEFT state matching the current facing.
//
// Optional feature macro: DOODLER_CTRL_AUTOFIRE_EN
//   defined   : a held shoot key re-fires as soon as COOLDOWN ends
//   undefined : a shoot key must be released for a frame before the next shot
//
// Ports:
//   frame_clk  frame-rate clock
//   Reset      synchronous active-low reset
//   keycodes   packed keycode slots, slot i = keycodes[8i+7:8i], 8'h00 = empty
//   freeze     pause: all state holds, fire forced low
//   state      0=RIGHT 1=LEFT 2=SHOOT 3=COOLDOWN
//   facing     0=right 1=left
//   shoot_dir  0=up 1=left 2=right, valid in SHOOT
//   fire       one-frame strobe in the first SHOOT frame
//   busy       high in SHOOT or COOLDOWN
module doodler_ctrl #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter logic [7:0]  KEY_LEFT        = 8'h04,
  parameter logic [7:0]  KEY_RIGHT       = 8'h07,
  parameter logic [7:0]  KEY_SHOOT_UP    = 8'd82,
  parameter logic [7:0]  KEY_SHOOT_LEFT  = 8'd80,
  parameter logic [7:0]  KEY_SHOOT_RIGHT = 8'd79,
  parameter int unsigned SHOOT_FRAMES    = 20,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned CNT_W           = 6
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic [NUM_KEYS*8-1:0] keycodes,
  input  logic                  freeze,
  output logic [1:0]            state,
  output logic                  facing,
  output logic [1:0]            shoot_dir,
  output logic                  fire,
  output logic                  busy
);

  typedef enum logic [1:0] {
    StRight    = 2'd0,
    StLeft     = 2'd1,
    StShoot    = 2'd2,
    StCooldown = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] ShootLast    = CNT_W'(SHOOT_FRAMES - 1);
  // Only compared when COOLDOWN_FRAMES != 0, so the wrap at 0 is harmless.
  localparam logic [CNT_W-1:0] CooldownLast = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam bit               CooldownEn   = (COOLDOWN_FRAMES != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             facing_q, facing_d;
  logic [1:0]       dir_q, dir_d;
  logic             fire_q, fire_d;
  logic             armed_q, armed_d;

  // Key decode over all slots.
  logic key_l, key_r, key_u, key_sl, key_sr, shoot_req;
  always_comb begin
    key_l  = 1'b0;
    key_r  = 1'b0;
    key_u  = 1'b0;
    key_sl = 1'b0;
    key_sr = 1'b0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (keycodes[8*i +: 8] == KEY_LEFT)        key_l  = 1'b1;
      if (keycodes[8*i +: 8] == KEY_RIGHT)       key_r  = 1'b1;
      if (keycodes[8*i +: 8] == KEY_SHOOT_UP)    key_u  = 1'b1;
      if (keycodes[8*i +: 8] == KEY_SHOOT_LEFT)  key_sl = 1'b1;
      if (keycodes[8*i +: 8] == KEY_SHOOT_RIGHT) key_sr = 1'b1;
    end
    shoot_req = key_u | key_sl | key_sr;
  end

  logic go_shoot;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    facing_d = facing_q;
    dir_d    = dir_q;
    armed_d  = armed_q;
    fire_d   = 1'b0;
    go_shoot = 1'b0;

    if (!freeze) begin
`ifndef DOODLER_CTRL_AUTOFIRE_EN
      if (!shoot_req) armed_d = 1'b1;
`endif
      case (state_q)
        StRight, StLeft: begin
          if (shoot_req && armed_q) begin
            go_shoot = 1'b1;
          end else if (key_l && !key_r) begin
            state_d  = StLeft;
            facing_d = 1'b1;
          end else if (key_r && !key_l) begin
            state_d  = StRight;
            facing_d = 1'b0;
          end
        end
        StShoot: begin
          if (cnt_q == ShootLast) begin
            cnt_d = '0;
            if (CooldownEn) begin
              state_d = StCooldown;
            end else begin
              state_d = facing_q ? StLeft : StRight;
`ifdef DOODLER_CTRL_AUTOFIRE_EN
              armed_d  = 1'b1;
              go_shoot = shoot_req;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StCooldown: begin
          if (key_l && !key_r) facing_d = 1'b1;
          else if (key_r && !key_l) facing_d = 1'b0;
          if (cnt_q == CooldownLast) begin
            cnt_d   = '0;
            state_d = facing_d ? StLeft : StRight;
`ifdef DOODLER_CTRL_AUTOFIRE_EN
            // Re-fire on the exit frame itself so the period is exactly
            // SHOOT_FRAMES + COOLDOWN_FRAMES.
            armed_d  = 1'b1;
            go_shoot = shoot_req;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StRight;
          cnt_d   = '0;
        end
      endcase

      if (go_shoot) begin
        state_d = StShoot;
        cnt_d   = '0;
        fire_d  = 1'b1;
        armed_d = 1'b0;
        // Priority up > left > right.
        dir_d   = key_u ? 2'd0 : (key_sl ? 2'd1 : 2'd2);
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state_q  <= StRight;
      cnt_q    <= '0;
      facing_q <= 1'b0;
      dir_q    <= 2'd0;
      fire_q   <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      facing_q <= facing_d;
      dir_q    <= dir_d;
      fire_q   <= fire_d;
      armed_q  <= armed_d;
    end
  end

  assign state     = state_q;
  assign facing    = facing_q;
  assign shoot_dir = dir_q;
  assign fire      = fire_q;
  assign busy      = (state_q == StShoot) || (state_q == StCooldown);

endmodule
